fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch.sv | 149 ++++++++++++++
 tb/tb_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_DISCARD = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {instr, pc} pairs; flush overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] count_r;

    // Entry storage; validity is tracked by the pointers, so no reset here.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding memory read, prefetch buffer, redirect flush.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
)(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [ILEN-1:0] instruction,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_addr_r;
    logic            issue_s;
    logic            push_s;
    logic            bypass_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW-1:0]   free_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_s;

    assign free_s       = DEPTH_C - fifo_count_s;
    assign push_entry_s = '{instr: imem_rdata, pc: req_addr_r};
    // An empty buffer with decode ready hands the word straight to the output.
    assign bypass_s     = push_s && fifo_empty_s && !stall;
    assign fifo_push_s  = push_s && !bypass_s && (!fifo_full_s || fifo_pop_s);
    assign fifo_pop_s   = !redirect_valid && !stall && !fifo_empty_s;
    assign imem_addr    = !imem_req ? 32'h0000_0000 :
                          (state_r == ST_IDLE) ? fetch_pc_r : req_addr_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) state_next_s = ST_WAIT;
                else         state_next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (imem_ack)            state_next_s = ST_IDLE;
                else if (redirect_valid) state_next_s = ST_DISCARD;
                else                     state_next_s = ST_WAIT;
            end
            ST_DISCARD: begin
                if (imem_ack) state_next_s = ST_IDLE;
                else          state_next_s = ST_DISCARD;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: request strobe, issue and accepted-data push.
    always_comb begin
        issue_s  = 1'b0;
        push_s   = 1'b0;
        imem_req = 1'b0;
        if (!rst) begin
            case (state_r)
                ST_IDLE: begin
                    issue_s  = !redirect_valid && (free_s >= CW'(1));
                    imem_req = issue_s;
                end
                ST_WAIT: begin
                    imem_req = 1'b1;
                    push_s   = imem_ack && !redirect_valid;
                end
                ST_DISCARD: imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end else begin
            imem_req = 1'b0;
        end
    end

    // Fetch pointer, request address latch and decode-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r  <= RESET_PC;
            req_addr_r  <= 32'h0000_0000;
            instruction <= 32'h0000_0000;
            pc_out      <= 32'h0000_0000;
            instr_valid <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_r <= word_align(redirect_pc);
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (issue_s) begin
                req_addr_r <= fetch_pc_r;
            end
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end else if (stall) begin
                instr_valid <= instr_valid;
            end else if (bypass_s) begin
                instruction <= imem_rdata;
                pc_out      <= req_addr_r;
                instr_valid <= 1'b1;
            end else if (!fifo_empty_s) begin
                instruction <= head_s.instr;
                pc_out      <= head_s.pc;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .flush (redirect_valid),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );
endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch against a queue-based in-order fetch model.
module tb_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, redirect_valid, stall, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out;
    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instruction(instruction), .instr_valid(instr_valid), .pc_out(pc_out)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000), .stall(1'b0),
        .instruction(w_instr), .instr_valid(w_valid), .pc_out(w_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0001 + (a ^ {a[15:0], a[31:16]});
    endfunction

    // Reference model state: fetch pointer, outstanding request, buffered words, output.
    logic [31:0] m_fetch_pc = 32'h0, m_pend_addr = 32'h0, m_pend_data = 32'h0;
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0;
    bit          m_pending = 1'b0, m_pend_drop = 1'b0, m_valid = 1'b0;
    int          m_lat = 0;
    int          next_lat = 1;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    bit          stray = 1'b0;
    bit          w_pend = 1'b0;
    logic [31:0] w_seen[$];
    bit          w_got = 1'b0;
    logic [31:0] w_first_pc = 32'h0, w_first_in = 32'h0;

    task automatic run_cycle(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        bit          ack, exp_issue, accept, w_next;
        rst            = r;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        ack            = (m_pending && m_lat == 0) || stray;
        imem_ack       = ack;
        imem_rdata     = (m_pending && ack) ? m_pend_data : $urandom;
        w_ack          = w_pend;
        #1;
        w_rdata = mem_word(w_addr);
        if (r) begin
            exp_issue = 1'b0;
            check("req_in_reset", 32'(imem_req), 32'h0);
            check("addr_in_reset", imem_addr, 32'h0);
        end else begin
            exp_issue = !m_pending && !rd && (q_pc.size() < DEPTH);
            check("imem_req", 32'(imem_req), 32'(m_pending || exp_issue));
            if (m_pending || exp_issue)
                check("imem_addr", imem_addr, m_pending ? m_pend_addr : m_fetch_pc);
        end
        if (r) w_seen.delete();
        else if (w_req && !w_pend && w_seen.size() < 3) w_seen.push_back(w_addr);
        w_next = !r && w_req && !w_pend;
        @(posedge clk);
        w_pend = w_next;
        if (r) begin
            m_fetch_pc = 32'h0;
            m_pending  = 1'b0;
            q_pc.delete();
            q_in.delete();
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
        end else begin
            accept = ack && m_pending && !m_pend_drop && !rd;
            if (accept) begin
                q_pc.push_back(m_pend_addr);
                q_in.push_back(m_pend_data);
            end
            if (m_pending && ack) begin
                m_pending = 1'b0;
            end else if (m_pending) begin
                m_lat--;
                if (rd) m_pend_drop = 1'b1;
            end
            if (exp_issue) begin
                m_pending   = 1'b1;
                m_pend_addr = m_fetch_pc;
                m_pend_drop = 1'b0;
                m_lat       = next_lat - 1;
                m_pend_data = ovr_en ? ovr_data : mem_word(m_fetch_pc);
            end
            if (rd) m_fetch_pc = rpc & 32'hFFFF_FFFC;
            else if (accept) m_fetch_pc = m_fetch_pc + 32'd4;
            if (rd) begin
                q_pc.delete();
                q_in.delete();
                m_valid = 1'b0;
            end else if (!st) begin
                if (q_pc.size() > 0) begin
                    m_pc    = q_pc.pop_front();
                    m_instr = q_in.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        #1;
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("pc_out", pc_out, m_pc);
        check("instruction", instruction, m_instr);
        if (r) w_got = 1'b0;
        else if (w_valid && !w_got) begin
            w_got      = 1'b1;
            w_first_pc = w_pc;
            w_first_in = w_instr;
        end
    endtask

    initial begin
        bit found;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; w_ack = 1'b0; w_rdata = 32'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Straight-line fetch with single-cycle acks.
        next_lat = 1;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_req_count", 32'(w_seen.size()), 32'd3);
        if (w_seen.size() == 3) begin
            check("wrap_addr0", w_seen[0], 32'hFFFF_FFFC);
            check("wrap_addr1", w_seen[1], 32'h0000_0000);
            check("wrap_addr2", w_seen[2], 32'h0000_0004);
        end
        check("wrap_first_valid", 32'(w_got), 32'h1);
        check("wrap_first_pc", w_first_pc, 32'hFFFF_FFFC);
        check("wrap_first_instr", w_first_in, mem_word(32'hFFFF_FFFC));

        // Long stall fills the buffer, then drains in order.
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect while waiting on a slow ack carrying a poisoned word.
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; next_lat = 4;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
            found = m_pending && (m_pend_data == 32'hDEAD_BEEF);
        end
        ovr_en = 1'b0;
        check("slow_req_found", 32'(found), 32'h1);
        next_lat = 1;
        run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect in the same cycle as the ack.
        next_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (m_pending && m_lat == 0 && !m_pend_drop) begin
                run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0203);
                found = 1'b1;
            end else begin
                run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
            end
        end
        check("redir_ack_found", 32'(found), 32'h1);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset mid-request, then a stray ack right after release.
        next_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
            found = m_pending;
        end
        check("reset_req_found", 32'(found), 32'h1);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        stray = 1'b1;
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit r, st, rd;
            next_lat = $urandom_range(1, 4);
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 3) == 0);
            rd = !r && ($urandom_range(0, 11) == 0);
            run_cycle(r, st, rd, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
